// File: rtl/ImgRszPkg.sv
// Shared widths and types for the power-of-two box-filter resizer.
package ImgRszPkg;

   localparam int CH_NUM       = 3;
   localparam int PXL_W        = 8;
   localparam int MAX_SCL_LOG2 = 3;
   localparam int SCL_W        = $clog2(MAX_SCL_LOG2 + 1);

   // A full 2^MAX x 2^MAX block of PXL_W-bit samples must sum without overflow.
   function automatic int acc_w(input int pxl_w, input int max_scl_log2);
      return pxl_w + 2 * max_scl_log2;
   endfunction

   localparam int ACC_W = acc_w(PXL_W, MAX_SCL_LOG2);

   typedef logic [CH_NUM-1:0][ACC_W-1:0] RszAccPxl_t;
   typedef logic [CH_NUM-1:0][PXL_W-1:0] RszPxl_t;

   typedef enum logic {IDLE, ACTIVE} RszState_t;

endpackage

// File: rtl/img_rsz_line_acc.sv
// Per-block-column line buffer: read-add-write of horizontal sums across the rows of a block.
// blk_sum is combinational; wr_en commits it at the addressed column.
module img_rsz_line_acc
   import ImgRszPkg::*;
#(
   parameter int MAX_RSZ_W = 320,
   localparam int IDX_W    = $clog2(MAX_RSZ_W)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_en,
   input  logic                        first_row,
   input  logic [IDX_W-1:0]            idx,
   input  logic [CH_NUM-1:0][ACC_W-1:0] hsum,
   output logic [CH_NUM-1:0][ACC_W-1:0] blk_sum
);

   RszAccPxl_t line_buf [MAX_RSZ_W];

   // The first row of a block overwrites, so stale sums from the previous block row never leak in.
   always_comb begin
      blk_sum = hsum;
      if (!first_row) begin
         for (int c = 0; c < CH_NUM; c++) begin
            blk_sum[c] = line_buf[idx][c] + hsum[c];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_RSZ_W; i++) begin
            line_buf[i] <= '0;
         end
      end else if (wr_en) begin
         line_buf[idx] <= blk_sum;
      end
   end

endmodule

// File: rtl/img_pow2_box_rsz.sv
// Raster-order 2^lx x 2^ly box-mean downscaler; output 1 cycle after a block's last pixel, input stalls while a held output blocks.
// Optional RSZ_ROUND_EN: round-half-up on the final shift instead of truncation.
module img_pow2_box_rsz
   import ImgRszPkg::*;
#(
   parameter int MAX_IMG_W  = 640,
   parameter int MAX_IMG_H  = 480,
   parameter int MAX_RSZ_W  = MAX_IMG_W / 2,
   localparam int IMG_X_W   = $clog2(MAX_IMG_W),
   localparam int IMG_Y_W   = $clog2(MAX_IMG_H)
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic [IMG_X_W-1:0]      ImgWidth,
   input  logic [IMG_Y_W-1:0]      ImgHeight,
   input  logic [SCL_W-1:0]        SclLog2X,
   input  logic [SCL_W-1:0]        SclLog2Y,
   input  logic [CH_NUM*PXL_W-1:0] PxlData,
   input  logic [IMG_X_W-1:0]      PxlX,
   input  logic [IMG_Y_W-1:0]      PxlY,
   input  logic                    PxlVld,
   output logic                    PxlRdy,
   output logic [CH_NUM*PXL_W-1:0] RszPxlData,
   output logic [IMG_X_W-1:0]      RszPxlX,
   output logic [IMG_Y_W-1:0]      RszPxlY,
   output logic                    RszPxlVld,
   input  logic                    RszPxlRdy,
   output logic                    RszFrmEnd,
   output logic                    SyncErr
);

   localparam int IDX_W = $clog2(MAX_RSZ_W);
   localparam int SH_W  = SCL_W + 1;

   RszState_t          state, state_nxt;
   logic [IMG_X_W-1:0] cfg_w, x_cnt, w, cx, bx, rsz_w, mask_x;
   logic [IMG_Y_W-1:0] cfg_h, y_cnt, h, cy, by, rsz_h, mask_y;
   logic [SCL_W-1:0]   cfg_lx, cfg_ly, lx, ly;
   logic [SH_W-1:0]    sh;
   logic [ACC_W-1:0]   rnd;
   logic               acc, in_blk, col_first, col_last, row_first, row_last;
   logic               x_last, last_pxl, lb_wr, emit, frm_end, sync_nxt;
   RszPxl_t            pxl, avg;
   RszAccPxl_t         hsum, hsum_nxt, blk_sum;

   assign PxlRdy = Reset && (!RszPxlVld || RszPxlRdy);
   assign acc    = PxlVld && PxlRdy;
   assign pxl    = PxlData;

   // In IDLE the accepted pixel opens a frame: it sits at (0,0) under the live configuration.
   always_comb begin
      w  = cfg_w;
      h  = cfg_h;
      lx = cfg_lx;
      ly = cfg_ly;
      cx = x_cnt;
      cy = y_cnt;
      if (state == IDLE) begin
         w  = ImgWidth;
         h  = ImgHeight;
         lx = SclLog2X;
         ly = SclLog2Y;
         cx = '0;
         cy = '0;
      end
   end

   assign mask_x    = ~({IMG_X_W{1'b1}} << lx);
   assign mask_y    = ~({IMG_Y_W{1'b1}} << ly);
   assign bx        = cx >> lx;
   assign by        = cy >> ly;
   assign rsz_w     = w >> lx;
   assign rsz_h     = h >> ly;
   assign in_blk    = (bx < rsz_w) && (by < rsz_h);
   assign col_first = (cx & mask_x) == '0;
   assign col_last  = (cx & mask_x) == mask_x;
   assign row_first = (cy & mask_y) == '0;
   assign row_last  = (cy & mask_y) == mask_y;
   assign x_last    = cx == w - IMG_X_W'(1);
   assign last_pxl  = x_last && (cy == h - IMG_Y_W'(1));
   assign lb_wr     = acc && in_blk && col_last;
   assign emit      = lb_wr && row_last;
   assign frm_end   = (bx == rsz_w - IMG_X_W'(1)) && (by == rsz_h - IMG_Y_W'(1));
   assign sync_nxt  = acc && ((PxlX != cx) || (PxlY != cy));
   assign sh        = SH_W'(lx) + SH_W'(ly);

`ifdef RSZ_ROUND_EN
   assign rnd = (sh == '0) ? '0 : (ACC_W'(1) << (sh - SH_W'(1)));
`else
   assign rnd = '0;
`endif

   always_comb begin
      hsum_nxt = '0;
      avg      = '0;
      for (int c = 0; c < CH_NUM; c++) begin
         hsum_nxt[c] = (col_first ? '0 : hsum[c]) + ACC_W'(pxl[c]);
         avg[c]      = PXL_W'((blk_sum[c] + rnd) >> sh);
      end
   end

   img_rsz_line_acc #(.MAX_RSZ_W(MAX_RSZ_W)) u_line_acc (
      .clk       (Clk),
      .rst_n     (Reset),
      .wr_en     (lb_wr),
      .first_row (row_first),
      .idx       (bx[IDX_W-1:0]),
      .hsum      (hsum_nxt),
      .blk_sum   (blk_sum)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (acc) begin
         state_nxt = last_pxl ? IDLE : ACTIVE;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cfg_w  <= '0;
         cfg_h  <= '0;
         cfg_lx <= '0;
         cfg_ly <= '0;
         x_cnt  <= '0;
         y_cnt  <= '0;
         hsum   <= '0;
      end else if (acc) begin
         if (state == IDLE) begin
            cfg_w  <= ImgWidth;
            cfg_h  <= ImgHeight;
            cfg_lx <= SclLog2X;
            cfg_ly <= SclLog2Y;
         end
         if (x_last) begin
            x_cnt <= '0;
            y_cnt <= cy + IMG_Y_W'(1);
         end else begin
            x_cnt <= cx + IMG_X_W'(1);
            y_cnt <= cy;
         end
         if (in_blk) begin
            hsum <= hsum_nxt;
         end
      end
   end

   // One-entry output stage; a pop and a push may share the same edge.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         RszPxlVld  <= 1'b0;
         RszPxlData <= '0;
         RszPxlX    <= '0;
         RszPxlY    <= '0;
         RszFrmEnd  <= 1'b0;
         SyncErr    <= 1'b0;
      end else begin
         SyncErr <= sync_nxt;
         if (emit) begin
            RszPxlVld  <= 1'b1;
            RszPxlData <= avg;
            RszPxlX    <= bx;
            RszPxlY    <= by;
            RszFrmEnd  <= frm_end;
         end else if (RszPxlRdy) begin
            RszPxlVld <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_img_pow2_box_rsz.sv
// Directed bench for img_pow2_box_rsz: frame runs with hand-computed block means, stalls, reset and sync-error injection.
module tb_img_pow2_box_rsz;

   localparam int XW = 10;
   localparam int YW = 9;
   localparam int SW = 2;
   localparam int BUDGET = 20000;

   logic          Clk = 1'b0;
   logic          Reset;
   logic [XW-1:0] ImgWidth, PxlX, RszPxlX;
   logic [YW-1:0] ImgHeight, PxlY, RszPxlY;
   logic [SW-1:0] SclLog2X, SclLog2Y;
   logic [23:0]   PxlData, RszPxlData;
   logic          PxlVld, PxlRdy, RszPxlVld, RszPxlRdy, RszFrmEnd, SyncErr;

   always #5 Clk = ~Clk;

   img_pow2_box_rsz dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .ImgWidth   (ImgWidth),
      .ImgHeight  (ImgHeight),
      .SclLog2X   (SclLog2X),
      .SclLog2Y   (SclLog2Y),
      .PxlData    (PxlData),
      .PxlX       (PxlX),
      .PxlY       (PxlY),
      .PxlVld     (PxlVld),
      .PxlRdy     (PxlRdy),
      .RszPxlData (RszPxlData),
      .RszPxlX    (RszPxlX),
      .RszPxlY    (RszPxlY),
      .RszPxlVld  (RszPxlVld),
      .RszPxlRdy  (RszPxlRdy),
      .RszFrmEnd  (RszFrmEnd),
      .SyncErr    (SyncErr)
   );

   typedef struct {
      logic [23:0] d;
      int          x;
      int          y;
      logic        e;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   logic exp_sync = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
      total++;
      assert (obs === req) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, req);
      end
   endtask

   function automatic logic [23:0] rep3(input int v);
      logic [7:0] b;
      b = 8'(v);
      return {b, b, b};
   endfunction

   // Mode 0: 4*x, 1: constant per 4x4 block (bx+by+c) with 0xFF outside, 2: x, 3: distinct per pixel.
   function automatic logic [23:0] pix(input int mode, input int x, input int y);
      logic [7:0] c0, c1, c2;
      case (mode)
         0: begin c0 = 8'(4 * x); c1 = c0; c2 = c0; end
         1: begin
            if (x >= 128 || y >= 64) begin
               c0 = 8'hFF; c1 = 8'hFF; c2 = 8'hFF;
            end else begin
               c0 = 8'((x >> 2) + (y >> 2));
               c1 = c0 + 8'd1;
               c2 = c0 + 8'd2;
            end
         end
         2: begin c0 = 8'(x); c1 = c0; c2 = c0; end
         default: begin c0 = 8'(x + 10 * y); c1 = 8'(100 + x); c2 = 8'(200 + y); end
      endcase
      return {c2, c1, c0};
   endfunction

   task automatic push(input logic [23:0] d, input int x, input int y, input logic e);
      exp_t t;
      t.d = d; t.x = x; t.y = y; t.e = e;
      exp_q.push_back(t);
   endtask

   // 8x4 at 2x2 with data 4*x: each block holds 8bx and 8bx+4, mean 8bx+2 on both output rows.
   task automatic push_8x4();
      for (int by = 0; by < 2; by++)
         for (int bx = 0; bx < 4; bx++)
            push(rep3(8 * bx + 2), bx, by, (bx == 3) && (by == 1));
   endtask

   task automatic tick(output logic acc, input logic inj_now);
      exp_t e;
      @(negedge Clk);
      acc = PxlVld && PxlRdy;
      chk("sync_err", SyncErr, exp_sync);
      if (RszPxlVld && RszPxlRdy) begin
         chk("out_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_dat", RszPxlData, e.d);
            chk("out_x", RszPxlX, e.x);
            chk("out_y", RszPxlY, e.y);
            chk("out_end", RszFrmEnd, e.e);
         end
      end
      exp_sync = acc && inj_now;
      @(posedge Clk);
      #1;
   endtask

   task automatic run_frame(input int w, input int h, input int lx, input int ly, input int mode,
                            input int stall, input int hold, input int inj, input int stop,
                            input int lat);
      int          idx = 0;
      int          gap = 0;
      int          hold_left = 0;
      int          budget = 0;
      int          x, y;
      logic        acc;
      logic        hold_done = 1'b0;
      logic        lat_pend = 1'b0;
      logic [23:0] held = '0;
      logic [23:0] last_dat = '0;
      ImgWidth  = XW'(w);
      ImgHeight = YW'(h);
      SclLog2X  = SW'(lx);
      SclLog2Y  = SW'(ly);
      while ((idx < w * h || exp_q.size() > 0) && budget < BUDGET) begin
         budget++;
         if (stop >= 0 && idx == stop) break;
         x = (idx < w * h) ? idx % w : 0;
         y = (idx < w * h) ? idx / w : 0;
         PxlVld  = (idx < w * h) && (gap == 0);
         PxlX    = XW'((idx == inj) ? 7 : x);
         PxlY    = YW'(y);
         PxlData = pix(mode, x, y);
         if (hold != 0 && !hold_done && RszPxlVld && hold_left == 0) begin
            hold_left = 10;
            held      = RszPxlData;
         end
         if (hold_left > 0) RszPxlRdy = 1'b0;
         else if (stall != 0) RszPxlRdy = ($urandom_range(0, 2) != 0);
         else RszPxlRdy = 1'b1;
         #1;
         if (hold_left > 0) begin
            chk("hold_vld", RszPxlVld, 1);
            chk("hold_dat", RszPxlData, held);
            chk("hold_pxl_rdy", PxlRdy, 0);
            hold_left--;
            if (hold_left == 0) hold_done = 1'b1;
         end
         if (lat_pend) begin
            chk("lat_vld", RszPxlVld, 1);
            chk("lat_dat", RszPxlData, last_dat);
         end
         tick(acc, idx == inj);
         lat_pend = acc && (lat != 0);
         last_dat = PxlData;
         if (acc) begin
            idx++;
            gap = (stall != 0) ? int'($urandom_range(0, 2)) : 0;
            ImgWidth  = XW'(3);
            ImgHeight = YW'(3);
            SclLog2X  = SW'(0);
            SclLog2Y  = SW'(1);
         end else if (gap > 0) begin
            gap--;
         end
      end
      chk("frame_budget", budget < BUDGET, 1);
      if (hold != 0) chk("hold_seen", hold_done, 1);
      chk("missing_out", exp_q.size(), 0);
      PxlVld    = 1'b0;
      RszPxlRdy = 1'b1;
   endtask

   logic acc_dummy;

   initial begin
      Reset     = 1'b0;
      PxlVld    = 1'b0;
      PxlX      = '0;
      PxlY      = '0;
      PxlData   = '0;
      ImgWidth  = '0;
      ImgHeight = '0;
      SclLog2X  = '0;
      SclLog2Y  = '0;
      RszPxlRdy = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_pxl_rdy", PxlRdy, 0);
      chk("rst_vld", RszPxlVld, 0);
      chk("rst_dat", RszPxlData, 0);
      chk("rst_x", RszPxlX, 0);
      chk("rst_y", RszPxlY, 0);
      chk("rst_end", RszFrmEnd, 0);
      chk("rst_sync", SyncErr, 0);
      Reset = 1'b1;
      #1;
      chk("pxl_rdy_after_rst", PxlRdy, 1);

      // 8x4, 2x2, no stalls
      push_8x4();
      run_frame(8, 4, 1, 1, 0, 0, 0, -1, -1, 0);

      // 129x65, 4x4, random stalls: 32x16 outputs, column 128 and row 64 dropped
      for (int by = 0; by < 16; by++)
         for (int bx = 0; bx < 32; bx++)
            push({8'(bx + by + 2), 8'(bx + by + 1), 8'(bx + by)}, bx, by, (bx == 31) && (by == 15));
      run_frame(129, 65, 2, 2, 1, 1, 0, -1, -1, 0);

      // 4x2, 2x2, data=x: block sums 2 and 10
`ifdef RSZ_ROUND_EN
      push(rep3(1), 0, 0, 1'b0);
      push(rep3(3), 1, 0, 1'b1);
`else
      push(rep3(0), 0, 0, 1'b0);
      push(rep3(2), 1, 0, 1'b1);
`endif
      run_frame(4, 2, 1, 1, 2, 0, 0, -1, -1, 0);

      // 1x1 passthrough, 5x3, latency checked per pixel
      for (int y = 0; y < 3; y++)
         for (int x = 0; x < 5; x++)
            push(pix(3, x, y), x, y, (x == 4) && (y == 2));
      run_frame(5, 3, 0, 0, 3, 0, 0, -1, -1, 1);

      // output held for 10 cycles at the first emission
      push_8x4();
      run_frame(8, 4, 1, 1, 0, 0, 1, -1, -1, 0);

      // partial frame up to pixel (3,1), then reset while it is presented
      push(rep3(2), 0, 0, 1'b0);
      run_frame(8, 4, 1, 1, 0, 0, 0, -1, 11, 0);
      ImgWidth  = XW'(8);
      ImgHeight = YW'(4);
      SclLog2X  = SW'(1);
      SclLog2Y  = SW'(1);
      PxlX      = XW'(3);
      PxlY      = YW'(1);
      PxlData   = pix(0, 3, 1);
      PxlVld    = 1'b1;
      Reset     = 1'b0;
      #1;
      chk("midrst_pxl_rdy", PxlRdy, 0);
      chk("midrst_vld", RszPxlVld, 0);
      chk("midrst_end", RszFrmEnd, 0);
      chk("midrst_dat", RszPxlData, 0);
      repeat (2) tick(acc_dummy, 1'b0);
      PxlVld = 1'b0;
      Reset  = 1'b1;
      tick(acc_dummy, 1'b0);
      chk("midrst_no_accept", acc_dummy, 0);
      push_8x4();
      run_frame(8, 4, 1, 1, 0, 0, 0, -1, -1, 0);

      // PxlX=7 presented at internal x=5: one SyncErr pulse, data still used at x=5
      push_8x4();
      run_frame(8, 4, 1, 1, 0, 0, 0, 5, -1, 0);
      tick(acc_dummy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
